debounce_multi: RTL
===================

# debounce_multi

Parametrised multi-channel switch/button debouncer, the successor to the single-channel `debounce` block. Each of CHANNELS noisy inputs gets its own stability counter. A channel's `clean` output follows its input only after the input has held a new level for STABLE_CYCLES consecutive clocks. The block also emits one-cycle rise/fall strobes and a busy flag. It sits between raw pad inputs and the control logic that consumes key/button events.

## Interface
- CHANNELS, 4, number of independent input channels (>=1)
- STABLE_CYCLES, 16, consecutive differing samples required to accept a new level (>=2)
- INIT_LEVEL, 1'b0, reset value of every `clean` bit and of any synchroniser flop
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- noise  input  CHANNELS  raw bouncing inputs
- clean  output  CHANNELS  debounced levels, registered
- rise  output  CHANNELS  1-cycle pulse when clean[i] goes 0->1
- fall  output  CHANNELS  1-cycle pulse when clean[i] goes 1->0
- busy  output  1  OR of all channels currently in COUNTING, registered

## Operation
- Sampled input s[i] is noise[i] (or its synchronised copy, see Configuration).
- Per channel, two states:
  - STABLE: cnt=0.
    - If s != clean, cnt<=1 and go to COUNTING.
  - COUNTING:
    - If s == clean, cnt<=0 and return to STABLE. The glitch is rejected and no pulse is issued.
    - Else if cnt == STABLE_CYCLES-1: clean<=s, cnt<=0, assert rise or fall for that cycle, go to STABLE.
    - Else cnt<=cnt+1.
- cnt width: CNT_W = $clog2(STABLE_CYCLES). cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- Channels are fully independent. Simultaneous events on different channels each produce their own strobe in the same cycle.
- rise[i] and fall[i] are never both high. A strobe is high only in the cycle in which clean[i] takes its new value.
- busy is registered: it is high in the cycle after any channel enters COUNTING, and low in the cycle after all channels are STABLE.
- Reset (reset==0 at a clk edge):
  - clean=all INIT_LEVEL; rise=fall=0; busy=0; all cnt=0; all channels STABLE.
  - Reset asserted mid-count discards partial counts. After release, a full STABLE_CYCLES run is required.
- X on noise after reset is the caller's problem; there is no X filtering.

## Timing
- Without sync: noise[i] changes before edge k and holds. clean[i] changes at edge k+STABLE_CYCLES-1, i.e. STABLE_CYCLES sampling edges including k.
- With sync: the same, plus 2 edges.
- A run of STABLE_CYCLES-1 differing samples followed by one matching sample produces no output change.
- Minimum pulse spacing on rise/fall for one channel is STABLE_CYCLES cycles.
- Outputs change only on the rising edge of clk. There is no combinational path from noise to any output.

## Configuration
- DEBOUNCE_SYNC_EN:
  - Defined: each noise bit passes through a 2-flop synchroniser, reset to INIT_LEVEL, before the counter. Latency is +2 cycles. Use for asynchronous pad inputs.
  - Undefined: noise is sampled directly by the counter logic. The caller guarantees inputs are synchronous to clk.

## Structure
- Package `debounce_pkg`:
  - state enum `db_state_t` {DB_STABLE, DB_COUNTING}
  - default-parameter constants
  - CNT_W helper function
- Sub-module `debounce_chan`: one channel (optional synchroniser, counter, FSM, clean/rise/fall registers).
- `debounce_multi` instantiates `debounce_chan` CHANNELS times via generate and ORs the per-channel counting flags into the busy register.

## Test plan
Bench configuration: CHANNELS=4, STABLE_CYCLES=8, INIT_LEVEL=0, sync off unless stated.
- Hold reset=0 for 2 edges with noise=4'b1111 -> clean=0000, rise=fall=0000, busy=0. After release, clean=1111 after 8 edges, with rise=1111 for exactly one cycle.
- noise[0] 0->1 held -> clean[0]=1 at the 8th edge, rise[0]=1 for that one cycle only, busy high on cycles 2..8 and low on cycle 9.
- noise[1] high for 7 edges then low -> clean[1] stays 0, no rise. Then high for 8 edges -> clean[1]=1.
- noise[2]=$random every cycle for 20 cycles, then held 1 -> clean[2] unchanged during the random phase, then 1 exactly 8 edges after the hold starts.
- Same edge: noise[0] 1->0 and noise[3] 0->1 -> at the 8th edge clean[0]=0 and clean[3]=1; fall[0] and rise[3] are high in the same single cycle.
- reset=0 after 5 counting edges on ch0 -> clean[0]=0, busy=0. After release, 8 more edges are needed. Separately, with DEBOUNCE_SYNC_EN defined, the ch0 change lands at the 10th edge.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel debouncer.
// Optional feature macro: DEBOUNCE_SYNC_EN (adds a 2-flop input synchroniser per channel).
package debounce_pkg;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_t;

    localparam int unsigned DEF_CHANNELS      = 4;
    localparam int unsigned DEF_STABLE_CYCLES = 16;
    localparam logic        DEF_INIT_LEVEL    = 1'b0;

    // Counter only has to reach STABLE_CYCLES-1.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: optional synchroniser, stability counter, FSM, clean/rise/fall registers.
// Optional feature macro: DEBOUNCE_SYNC_EN.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic        INIT_LEVEL    = DEF_INIT_LEVEL
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_noise,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_counting
);

    localparam int unsigned      CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic w_sample;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sync <= {2{INIT_LEVEL}};
        end else begin
            r_sync <= {r_sync[0], i_noise};
        end
    end

    assign w_sample = r_sync[1];
`else
    assign w_sample = i_noise;
`endif

    db_state_t        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_clean, w_clean_d;
    logic             r_rise, w_rise_d;
    logic             r_fall, w_fall_d;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
            r_clean <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_clean <= w_clean_d;
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_clean_d = r_clean;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;
        case (r_state)
            DB_STABLE: begin
                if (w_sample != r_clean) begin
                    w_cnt_d   = CNT_W'(1);
                    w_state_d = DB_COUNTING;
                end
            end
            DB_COUNTING: begin
                if (w_sample == r_clean) begin
                    // Glitch shorter than the stability window: drop it silently.
                    w_cnt_d   = '0;
                    w_state_d = DB_STABLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_clean_d = w_sample;
                    w_rise_d  = w_sample;
                    w_fall_d  = ~w_sample;
                    w_cnt_d   = '0;
                    w_state_d = DB_STABLE;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign o_clean    = r_clean;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_counting = (r_state == DB_COUNTING);

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: CHANNELS independent debounce_chan instances plus a registered busy.
// Optional feature macro: DEBOUNCE_SYNC_EN (passed through to every channel).
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS      = DEF_CHANNELS,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic        INIT_LEVEL    = DEF_INIT_LEVEL
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_noise,
    output logic [CHANNELS-1:0] o_clean,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic                o_busy
);

    logic [CHANNELS-1:0] w_counting;
    logic                r_busy;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .INIT_LEVEL   (INIT_LEVEL)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_noise   (i_noise[g]),
            .o_clean   (o_clean[g]),
            .o_rise    (o_rise[g]),
            .o_fall    (o_fall[g]),
            .o_counting(w_counting[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_counting;
        end
    end

    assign o_busy = r_busy;

endmodule
